// File: rtl/pacemaker_io_pkg.sv
// Shared constants for the pacemaker I/O front end: clock rate, key timing
// defaults and the role assigned to each key channel.
package pacemaker_io_pkg;

  localparam int N_KEYS_DEFAULT = 3;
  localparam int CLK_HZ         = 50_000_000;

  // 10 ms debounce and 50 ms minimum visible press at the system clock
  localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 100;
  localparam int STRETCH_CYCLES_DEFAULT  = CLK_HZ / 20;

  // Key channel roles: atrial sense, ventricular sense, auxiliary
  localparam int KEY_AS  = 0;
  localparam int KEY_VS  = 1;
  localparam int KEY_AUX = 2;

endpackage : pacemaker_io_pkg

// File: rtl/key_event_conditioner_if.sv
// Key bundle between the raw button pins / firmware PIO side and the
// conditioner. The master drives pins and clear strobes; the slave (the
// conditioner) returns the conditioned key views.
interface key_event_conditioner_if #(
  parameter int N_KEYS = 3
);

  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] clr_overrun;
  logic [N_KEYS-1:0] keys_export;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press_pulse;
  logic [N_KEYS-1:0] overrun;

  modport master (
    output key_raw,
    output clr_overrun,
    input  keys_export,
    input  key_level,
    input  key_press_pulse,
    input  overrun
  );

  modport slave (
    input  key_raw,
    input  clr_overrun,
    output keys_export,
    output key_level,
    output key_press_pulse,
    output overrun
  );

endinterface : key_event_conditioner_if

// File: rtl/key_channel.sv
// One key channel: 2-FF synchroniser, polarity normalisation, debounce,
// press-edge detection, minimum-width stretch and sticky overrun flag.
module key_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STRETCH_CYCLES  = 8,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  input  logic clr_overrun,
  output logic keys_export,
  output logic key_level,
  output logic key_press_pulse,
  output logic overrun
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);

  localparam logic          IDLE_PIN = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] S_LOAD   = SW'(STRETCH_CYCLES);

  logic          sync_p0;
  logic          sync_p1;
  logic          s;
  logic [DW-1:0] dcnt;
  logic          level_d;
  logic [SW-1:0] scnt;
  logic          stretch_active;

  // Stage p0/p1: bring the asynchronous pin into the clock domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= IDLE_PIN;
      sync_p1 <= IDLE_PIN;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  assign s = KEY_ACTIVE_LOW ? ~sync_p1 : sync_p1;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt      <= '0;
      key_level <= 1'b0;
    end else if (s == key_level) begin
      dcnt <= '0;
    end else if (dcnt == D_LAST) begin
      key_level <= s;
      dcnt      <= '0;
    end else begin
      dcnt <= dcnt + 1'b1;
    end
  end

  // One-cycle pulse on each accepted press; releases are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d         <= 1'b0;
      key_press_pulse <= 1'b0;
    end else begin
      level_d         <= key_level;
      key_press_pulse <= key_level & ~level_d;
    end
  end

  assign stretch_active = (scnt != '0);

  // Reload the stretch window on a press, otherwise count it down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= '0;
    end else if (key_press_pulse) begin
      scnt <= S_LOAD;
    end else if (stretch_active) begin
      scnt <= scnt - 1'b1;
    end
  end

  // Firmware-visible key: held while pressed or while the window runs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keys_export <= 1'b0;
    end else begin
      keys_export <= key_level | stretch_active;
    end
  end

  // Sticky flag for a press that lands inside a running window; set beats clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (key_press_pulse && stretch_active) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule : key_channel

// File: rtl/key_event_conditioner.sv
// Conditions the DE2 push-buttons feeding the Nios keys PIO: synchronised,
// debounced, stretched key levels plus per-key press pulses and overrun flags.
module key_event_conditioner
  import pacemaker_io_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int STRETCH_CYCLES  = STRETCH_CYCLES_DEFAULT,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  key_event_conditioner_if.slave  bus
);

  if (N_KEYS < 1) begin : g_bad_n_keys
    $error("key_event_conditioner: N_KEYS must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_event_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (STRETCH_CYCLES < 1) begin : g_bad_stretch
    $error("key_event_conditioner: STRETCH_CYCLES must be >= 1");
  end

  logic [N_KEYS-1:0] export_v;
  logic [N_KEYS-1:0] level_v;
  logic [N_KEYS-1:0] pulse_v;
  logic [N_KEYS-1:0] overrun_v;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STRETCH_CYCLES  (STRETCH_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_ch (
      .clk             (clk_clk),
      .rst             (reset_reset),
      .key_raw         (bus.key_raw[i]),
      .clr_overrun     (bus.clr_overrun[i]),
      .keys_export     (export_v[i]),
      .key_level       (level_v[i]),
      .key_press_pulse (pulse_v[i]),
      .overrun         (overrun_v[i])
    );
  end

  assign bus.keys_export     = export_v;
  assign bus.key_level       = level_v;
  assign bus.key_press_pulse = pulse_v;
  assign bus.overrun         = overrun_v;

endmodule : key_event_conditioner

// File: tb/tb_key_event_conditioner.sv
// Bench for key_event_conditioner with short debounce/stretch windows.
// Stimulus queues hand-computed output changes; a monitor pops one entry for
// every change it observes on the output word and compares cycle and value.
module tb_key_event_conditioner;
  import pacemaker_io_pkg::*;

  localparam int NK = 3;
  localparam int DB = 4;
  localparam int ST = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_event_conditioner_if #(.N_KEYS(NK)) bus ();

  key_event_conditioner #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (DB),
    .STRETCH_CYCLES  (ST),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  typedef struct {
    int          cyc;
    logic [11:0] w;
    int          id;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          ev_id    = 0;
  bit          mon_en   = 1'b0;
  logic [11:0] prev_w   = 12'h000;
  logic [11:0] mon_cur;
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Output word layout: {overrun, key_press_pulse, keys_export, key_level}
  function automatic logic [11:0] outw();
    return {bus.overrun, bus.key_press_pulse, bus.keys_export, bus.key_level};
  endfunction

  function automatic logic [11:0] ev(input logic [2:0] l, input logic [2:0] e,
                                     input logic [2:0] p, input logic [2:0] o);
    return {o, p, e, l};
  endfunction

  task automatic push(input int at, input logic [11:0] w);
    exp_t x;
    x.cyc = at;
    x.w   = w;
    x.id  = ev_id;
    ev_id++;
    q.push_back(x);
  endtask

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every change of the output word must match the next queued entry
  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = outw();
      if (mon_cur !== prev_w) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_change: cyc %0d got %h want unchanged %h", cyc, mon_cur, prev_w);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.cyc == cyc && mon_e.w === mon_cur) n_pass++;
          else $display("FAIL ev%0d: got cyc %0d out %h want cyc %0d out %h",
                        mon_e.id, cyc, mon_cur, mon_e.cyc, mon_e.w);
        end
      end
      prev_w = mon_cur;
    end
  end

  initial begin
    int p;
    int r;
    bus.key_raw     = 3'b111;
    bus.clr_overrun = 3'b000;

    // 1: reset with keys idle
    #1 rst = 1'b1;
    #1 check("reset_outputs", outw(), 12'h000);
    prev_w = 12'h000;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_held", outw(), 12'h000);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_idle", outw(), 12'h000);

    // 2: long press on ch0
    @(negedge clk);
    p = cyc;
    bus.key_raw[KEY_AS] = 1'b0;
    push(p + 6,  ev(3'b001, 3'b000, 3'b000, 3'b000));
    push(p + 7,  ev(3'b001, 3'b001, 3'b001, 3'b000));
    push(p + 8,  ev(3'b001, 3'b001, 3'b000, 3'b000));
    push(p + 26, ev(3'b000, 3'b001, 3'b000, 3'b000));
    push(p + 27, 12'h000);
    repeat (20) @(negedge clk);
    bus.key_raw[KEY_AS] = 1'b1;
    repeat (12) @(negedge clk);
    check("long_press_done", outw(), 12'h000);

    // 3: bounce on ch1 never settles long enough
    for (int i = 0; i < 6; i++) begin
      bus.key_raw[KEY_VS] = (i % 2 == 1);
      repeat (2) @(negedge clk);
    end
    bus.key_raw[KEY_VS] = 1'b1;
    repeat (16) @(negedge clk);
    check("bounce_ch1_quiet", outw(), 12'h000);

    // 4: short press on ch2, stretch covers the release
    p = cyc;
    bus.key_raw[KEY_AUX] = 1'b0;
    push(p + 6,  ev(3'b100, 3'b000, 3'b000, 3'b000));
    push(p + 7,  ev(3'b100, 3'b100, 3'b100, 3'b000));
    push(p + 8,  ev(3'b100, 3'b100, 3'b000, 3'b000));
    push(p + 11, ev(3'b000, 3'b100, 3'b000, 3'b000));
    push(p + 17, 12'h000);
    repeat (5) @(negedge clk);
    bus.key_raw[KEY_AUX] = 1'b1;
    repeat (20) @(negedge clk);
    check("short_press_no_overrun", outw(), 12'h000);

    // 5: second press inside the stretch window on ch0
    p = cyc;
    bus.key_raw[KEY_AS] = 1'b0;
    push(p + 6,  ev(3'b001, 3'b000, 3'b000, 3'b000));
    push(p + 7,  ev(3'b001, 3'b001, 3'b001, 3'b000));
    push(p + 8,  ev(3'b001, 3'b001, 3'b000, 3'b000));
    push(p + 10, ev(3'b000, 3'b001, 3'b000, 3'b000));
    push(p + 14, ev(3'b001, 3'b001, 3'b000, 3'b000));
    push(p + 15, ev(3'b001, 3'b001, 3'b001, 3'b000));
    push(p + 16, ev(3'b001, 3'b001, 3'b000, 3'b001));
    push(p + 18, ev(3'b000, 3'b001, 3'b000, 3'b001));
    push(p + 25, ev(3'b000, 3'b000, 3'b000, 3'b001));
    push(p + 26, 12'h000);
    repeat (4) @(negedge clk);
    bus.key_raw[KEY_AS] = 1'b1;
    repeat (4) @(negedge clk);
    bus.key_raw[KEY_AS] = 1'b0;
    repeat (4) @(negedge clk);
    bus.key_raw[KEY_AS] = 1'b1;
    repeat (3) @(negedge clk);
    bus.clr_overrun[KEY_AS] = 1'b1;
    @(negedge clk);
    bus.clr_overrun[KEY_AS] = 1'b0;
    check("overrun_set_wins", outw(), ev(3'b001, 3'b001, 3'b000, 3'b001));
    repeat (9) @(negedge clk);
    bus.clr_overrun[KEY_AS] = 1'b1;
    @(negedge clk);
    bus.clr_overrun[KEY_AS] = 1'b0;
    repeat (6) @(negedge clk);
    check("overrun_cleared", outw(), 12'h000);

    // 6: asynchronous reset while ch1 is held and stretched
    p = cyc;
    bus.key_raw[KEY_VS] = 1'b0;
    push(p + 6,  ev(3'b010, 3'b000, 3'b000, 3'b000));
    push(p + 7,  ev(3'b010, 3'b010, 3'b010, 3'b000));
    push(p + 8,  ev(3'b010, 3'b010, 3'b000, 3'b000));
    push(p + 11, 12'h000);
    repeat (10) @(negedge clk);
    check("export_before_reset", outw(), ev(3'b010, 3'b010, 3'b000, 3'b000));
    #2 rst = 1'b1;
    #1 check("async_reset", outw(), 12'h000);
    repeat (3) @(negedge clk);
    r = cyc;
    rst = 1'b0;
    push(r + 6,  ev(3'b010, 3'b000, 3'b000, 3'b000));
    push(r + 7,  ev(3'b010, 3'b010, 3'b010, 3'b000));
    push(r + 8,  ev(3'b010, 3'b010, 3'b000, 3'b000));
    push(r + 18, ev(3'b000, 3'b010, 3'b000, 3'b000));
    push(r + 19, 12'h000);
    repeat (12) @(negedge clk);
    bus.key_raw[KEY_VS] = 1'b1;
    repeat (14) @(negedge clk);
    check("final_idle", outw(), 12'h000);

    // Any expected change never observed counts as a failed comparison
    while (q.size() != 0) begin
      mon_e = q.pop_front();
      n_checks++;
      $display("FAIL ev%0d_missing: got no change want cyc %0d out %h", mon_e.id, mon_e.cyc, mon_e.w);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_key_event_conditioner
